// File: rtl/pipe_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
// master drives operands and out_ready; slave is the pipeline itself.
interface pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_addsub.sv
// Carry-pipelined add/subtract: stage k adds slice k with the registered carry
// of stage k-1; operands and partial sums ride along in per-stage registers.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    logic [WIDTH-1:0]  a_st [STAGES];
    logic [WIDTH-1:0]  b_st [STAGES];
    logic [WIDTH-1:0]  s_st [STAGES];
    logic [STAGES-1:0] c_st;
    logic [STAGES-1:0] v_st;

    logic stall;
    logic advance;

    assign stall         = v_st[STAGES-1] & ~bus.out_ready;
    assign advance       = ~stall;
    assign bus.in_ready  = ~stall & ~rst;
    assign bus.out_valid = v_st[STAGES-1];
    assign bus.sum       = s_st[STAGES-1];
    assign bus.cout      = c_st[STAGES-1];
    // b_st already holds the effective (possibly inverted) operand B
    assign bus.ovf       = (a_st[STAGES-1][WIDTH-1] == b_st[STAGES-1][WIDTH-1]) &
                           (s_st[STAGES-1][WIDTH-1] != a_st[STAGES-1][WIDTH-1]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [SLICE:0]   part;
        logic [WIDTH-1:0] s_next;

        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] b_r;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_head
            assign a_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.cin ^ bus.sub;
            assign s_in = '0;
            assign v_in = bus.in_valid;
        end else begin : g_body
            assign a_in = a_st[k-1];
            assign b_in = b_st[k-1];
            assign c_in = c_st[k-1];
            assign s_in = s_st[k-1];
            assign v_in = v_st[k-1];
        end

        assign part = {1'b0, a_in[k*SLICE +: SLICE]} + {1'b0, b_in[k*SLICE +: SLICE]}
                    + (SLICE+1)'(c_in);

        always_comb begin
            s_next = s_in;
            s_next[k*SLICE +: SLICE] = part[SLICE-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
            end else if (advance) begin
                v_r <= v_in;
                c_r <= part[SLICE];
                a_r <= a_in;
                b_r <= b_in;
                s_r <= s_next;
            end
        end

        assign a_st[k] = a_r;
        assign b_st[k] = b_r;
        assign s_st[k] = s_r;
        assign c_st[k] = c_r;
        assign v_st[k] = v_r;
    end
endmodule
